// File: rtl/gfx_pkg.sv
// gfx_pkg: shared constants and types for the text console and glyph renderer.
// Rev 1.0
`default_nettype none

package gfx_pkg;

  localparam int CELL_PX    = 16;
  localparam int CELL_SHIFT = 4;

  localparam logic [6:0] CHR_BS       = 7'h08;
  localparam logic [6:0] CHR_LF       = 7'h0A;
  localparam logic [6:0] CHR_FF       = 7'h0C;
  localparam logic [6:0] CHR_CR       = 7'h0D;
  localparam logic [6:0] CHR_BLANK    = 7'h00;
  localparam logic [6:0] CHR_PRINT_LO = 7'h20;
  localparam logic [6:0] CHR_PRINT_HI = 7'h7E;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } console_state_t;

endpackage

`default_nettype wire

// File: rtl/char_ram.sv
// char_ram: simple dual-port RAM, one write port and one registered read port.
// Rev 1.0
`default_nettype none

module char_ram #(
  parameter int DEPTH = 1200,
  parameter int WIDTH = 7,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/text_console.sv
// text_console: character frame store and writer feeding gfx; blinking cursor
// overlay is built only when TEXT_CONSOLE_CURSOR_EN is defined. Rev 1.0
`default_nettype none

module text_console
  import gfx_pkg::*;
#(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int BLINK_LOG2 = 24
) (
  input  logic                    pix_clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  input  logic [6:0]              wr_char,
  output logic                    wr_ready,
  input  logic [11:0]             i_x,
  input  logic [11:0]             i_y,
  output logic [6:0]              character,
  output logic                    o_cursor,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic [$clog2(ROWS)-1:0] cur_row
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(COLS * ROWS);

  console_state_t state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           rd_ok_q;

  logic           w_we;
  logic [AW-1:0]  w_waddr;
  logic [6:0]     w_wdata;
  logic [RW-1:0]  w_row_next;
  logic [11:0]    w_rcol, w_rrow;
  logic           w_oob;
  logic [AW-1:0]  w_raddr;
  logic [6:0]     w_rdata;

  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  assign w_row_next = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign wr_ready   = (state_q == IDLE);
  assign cur_col    = col_q;
  assign cur_row    = row_q;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ALL;
      ptr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rd_ok_q <= !w_oob;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    row_d   = row_q;
    w_we    = 1'b0;
    w_waddr = addr_of(row_q, col_q);
    w_wdata = CHR_BLANK;
    case (state_q)
      CLEAR_ALL: begin
        w_we    = 1'b1;
        w_waddr = ptr_q;
        if (ptr_q == AW'(COLS * ROWS - 1)) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      CLEAR_ROW: begin
        w_we    = 1'b1;
        w_waddr = addr_of(row_q, CW'(ptr_q));
        if (ptr_q == AW'(COLS - 1)) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (wr_valid) begin
          if (wr_char >= CHR_PRINT_LO && wr_char <= CHR_PRINT_HI) begin
            w_we    = 1'b1;
            w_wdata = wr_char;
            if (col_q == CW'(COLS - 1)) begin
              col_d   = '0;
              row_d   = w_row_next;
              ptr_d   = '0;
              state_d = CLEAR_ROW;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (wr_char == CHR_LF || wr_char == CHR_CR) begin
            col_d   = '0;
            row_d   = w_row_next;
            ptr_d   = '0;
            state_d = CLEAR_ROW;
          end else if (wr_char == CHR_BS) begin
            if (col_q != '0) begin
              col_d = col_q - 1'b1;
            end else if (row_q != '0) begin
              col_d = CW'(COLS - 1);
              row_d = row_q - 1'b1;
            end
            // Erase lands on the post-move cell, in the same edge as the move.
            w_we    = 1'b1;
            w_waddr = addr_of(row_d, col_d);
          end else if (wr_char == CHR_FF) begin
            col_d   = '0;
            row_d   = '0;
            ptr_d   = '0;
            state_d = CLEAR_ALL;
          end
        end
      end
      default: begin
        ptr_d   = '0;
        state_d = CLEAR_ALL;
      end
    endcase
  end

  assign w_rcol  = i_x >> CELL_SHIFT;
  assign w_rrow  = i_y >> CELL_SHIFT;
  assign w_oob   = (w_rcol >= 12'(COLS)) || (w_rrow >= 12'(ROWS));
  assign w_raddr = w_oob ? '0 : addr_of(w_rrow[RW-1:0], w_rcol[CW-1:0]);

  char_ram #(
    .DEPTH (COLS * ROWS),
    .WIDTH (7),
    .AW    (AW)
  ) u_char_ram (
    .clk_i   (pix_clk),
    .we_i    (w_we),
    .waddr_i (w_waddr),
    .wdata_i (w_wdata),
    .raddr_i (w_raddr),
    .rdata_o (w_rdata)
  );

  // The array has no reset, so the output is gated until a clean read lands.
  assign character = rd_ok_q ? w_rdata : CHR_BLANK;

`ifdef TEXT_CONSOLE_CURSOR_EN
  logic [BLINK_LOG2-1:0] blink_q;
  logic                  cursor_q;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      blink_q  <= '0;
      cursor_q <= 1'b0;
    end else begin
      blink_q  <= blink_q + 1'b1;
      cursor_q <= (state_q == IDLE) && !w_oob && (w_rcol == 12'(col_q)) &&
                  (w_rrow == 12'(row_q)) && blink_q[BLINK_LOG2-1];
    end
  end

  assign o_cursor = cursor_q;
`else
  assign o_cursor = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_text_console.sv
// tb_text_console: directed self-checking bench for text_console (COLS=40, ROWS=30).
// Rev 1.0
`default_nettype none

module tb_text_console;

  logic        pix_clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_char = 7'h00;
  logic        wr_ready;
  logic [11:0] i_x = 12'd0;
  logic [11:0] i_y = 12'd0;
  logic [6:0]  character;
  logic        o_cursor;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;

  int total = 0;
  int bad   = 0;

  always #5 pix_clk = ~pix_clk;

  text_console #(.COLS(40), .ROWS(30), .BLINK_LOG2(4)) dut (
    .pix_clk   (pix_clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_char   (wr_char),
    .wr_ready  (wr_ready),
    .i_x       (i_x),
    .i_y       (i_y),
    .character (character),
    .o_cursor  (o_cursor),
    .cur_col   (cur_col),
    .cur_row   (cur_row)
  );

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [6:0] c);
    int n;
    wait_ready(n);
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready char=%h got wr_ready=%b want 1 after %0d cycles", c, wr_ready, n);
    end
    wr_valid = 1'b1;
    wr_char  = c;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_px(input int x, input int y, output logic [6:0] d);
    i_x = 12'(x);
    i_y = 12'(y);
    tick();
    d = character;
  endtask

  task automatic rd(input int col, input int row, output logic [6:0] d);
    rd_px(col * 16 + 3, row * 16 + 9, d);
  endtask

  task automatic test_reset();
    int n;
    int nz;
    logic [6:0] d;
    rst = 1'b1;
    #3;
    total++;
    if (wr_ready !== 1'b0 || character !== 7'h00 || o_cursor !== 1'b0 || cur_col !== 6'd0 || cur_row !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b chr=%h cur=%b pos=(%0d,%0d) want 0,00,0,(0,0)",
               wr_ready, character, o_cursor, cur_col, cur_row);
    end
    tick();
    tick();
    rst = 1'b0;
    wait_ready(n);
    total++;
    if (n != 1200) begin
      bad++;
      $display("FAIL reset_clear_len got %0d cycles want 1200", n);
    end
    nz = 0;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 40; c++) begin
        rd(c, r, d);
        if (d !== 7'h00) nz++;
      end
    end
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL reset_cells_blank got %0d nonblank cells want 0", nz);
    end
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd0) begin
      bad++;
      $display("FAIL reset_cursor got (%0d,%0d) want (0,0)", cur_col, cur_row);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] d;
    logic [6:0] seq [3];
    seq[0] = 7'h31;
    seq[1] = 7'h2B;
    seq[2] = 7'h32;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_char = seq[i];
      tick();
      total++;
      if (cur_col !== 6'(i + 1) || wr_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_step%0d got col=%0d rdy=%b want col=%0d rdy=1", i, cur_col, wr_ready, i + 1);
      end
    end
    wr_valid = 1'b0;
    rd_px(16, 0, d);
    total++;
    if (d !== 7'h2B) begin
      bad++;
      $display("FAIL b2b_read_plus got %h want 2b", d);
    end
    rd(2, 0, d);
    total++;
    if (d !== 7'h32) begin
      bad++;
      $display("FAIL b2b_read_two got %h want 32", d);
    end
  endtask

  task automatic test_form_feed();
    int n;
    logic [6:0] d;
    send(7'h0C);
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd0 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL ff_entry got pos=(%0d,%0d) rdy=%b want (0,0) rdy=0", cur_col, cur_row, wr_ready);
    end
    wait_ready(n);
    total++;
    if (n != 1200) begin
      bad++;
      $display("FAIL ff_clear_len got %0d cycles want 1200", n);
    end
    rd(1, 0, d);
    total++;
    if (d !== 7'h00) begin
      bad++;
      $display("FAIL ff_cell_cleared got %h want 00", d);
    end
  endtask

  task automatic test_line_wrap();
    int n;
    int nz;
    logic [6:0] d;
    wr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_char = 7'(8'h41 + (i % 26));
      tick();
    end
    wr_valid = 1'b0;
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd1 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL wrap_cursor got pos=(%0d,%0d) rdy=%b want (0,1) rdy=0", cur_col, cur_row, wr_ready);
    end
    wait_ready(n);
    total++;
    if (n != 40) begin
      bad++;
      $display("FAIL wrap_clear_len got %0d cycles want 40", n);
    end
    rd(39, 0, d);
    total++;
    if (d !== 7'h4E) begin
      bad++;
      $display("FAIL wrap_last_cell got %h want 4e", d);
    end
    rd(0, 0, d);
    total++;
    if (d !== 7'h41) begin
      bad++;
      $display("FAIL wrap_first_cell got %h want 41", d);
    end
    nz = 0;
    for (int c = 0; c < 40; c++) begin
      rd(c, 1, d);
      if (d !== 7'h00) nz++;
    end
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL wrap_row1_blank got %0d nonblank want 0", nz);
    end
  endtask

  task automatic test_lf_wrap();
    int n;
    logic [6:0] d;
    for (int i = 0; i < 27; i++) send(7'h0A);
    send(7'h51);
    send(7'h0A);
    wait_ready(n);
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd29) begin
      bad++;
      $display("FAIL lf_reach_last got (%0d,%0d) want (0,29)", cur_col, cur_row);
    end
    send(7'h0A);
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd0 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL lf_wrap_cursor got pos=(%0d,%0d) rdy=%b want (0,0) rdy=0", cur_col, cur_row, wr_ready);
    end
    wait_ready(n);
    total++;
    if (n != 40) begin
      bad++;
      $display("FAIL lf_clear_len got %0d cycles want 40", n);
    end
    rd(0, 0, d);
    total++;
    if (d !== 7'h00) begin
      bad++;
      $display("FAIL lf_row0_first got %h want 00", d);
    end
    rd(39, 0, d);
    total++;
    if (d !== 7'h00) begin
      bad++;
      $display("FAIL lf_row0_last got %h want 00", d);
    end
    rd(0, 28, d);
    total++;
    if (d !== 7'h51) begin
      bad++;
      $display("FAIL lf_row28_kept got %h want 51", d);
    end
  endtask

  task automatic test_backspace();
    int n;
    logic [6:0] d;
    wait_ready(n);
    wr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_char = 7'(8'h61 + (i % 26));
      tick();
    end
    wr_valid = 1'b0;
    send(7'h08);
    total++;
    if (cur_col !== 6'd39 || cur_row !== 5'd0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL bs_row_back got pos=(%0d,%0d) rdy=%b want (39,0) rdy=1", cur_col, cur_row, wr_ready);
    end
    rd(39, 0, d);
    total++;
    if (d !== 7'h00) begin
      bad++;
      $display("FAIL bs_erase_39 got %h want 00", d);
    end
    rd(38, 0, d);
    total++;
    if (d !== 7'h6D) begin
      bad++;
      $display("FAIL bs_keep_38 got %h want 6d", d);
    end
    wr_valid = 1'b1;
    wr_char  = 7'h08;
    for (int i = 0; i < 39; i++) tick();
    wr_valid = 1'b0;
    rd(0, 0, d);
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd0 || d !== 7'h00) begin
      bad++;
      $display("FAIL bs_to_origin got pos=(%0d,%0d) cell=%h want (0,0) 00", cur_col, cur_row, d);
    end
    send(7'h08);
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL bs_at_origin got pos=(%0d,%0d) rdy=%b want (0,0) rdy=1", cur_col, cur_row, wr_ready);
    end
    send(7'h01);
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL other_code got pos=(%0d,%0d) rdy=%b want (0,0) rdy=1", cur_col, cur_row, wr_ready);
    end
  endtask

  task automatic test_cr_oob();
    logic [6:0] d;
    send(7'h41);
    send(7'h0D);
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd1 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL cr_cursor got pos=(%0d,%0d) rdy=%b want (0,1) rdy=0", cur_col, cur_row, wr_ready);
    end
    send(7'h4B);
    rd_px(0, 16, d);
    total++;
    if (d !== 7'h4B) begin
      bad++;
      $display("FAIL cr_cell_k got %h want 4b", d);
    end
    rd_px(640, 0, d);
    total++;
    if (d !== 7'h00) begin
      bad++;
      $display("FAIL oob_x640 got %h want 00", d);
    end
    rd_px(0, 480, d);
    total++;
    if (d !== 7'h00) begin
      bad++;
      $display("FAIL oob_y480 got %h want 00", d);
    end
    rd_px(4095, 4095, d);
    total++;
    if (d !== 7'h00) begin
      bad++;
      $display("FAIL oob_max got %h want 00", d);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic [6:0] d;
    send(7'h0A);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #2;
    total++;
    if (cur_col !== 6'd0 || cur_row !== 5'd0 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state got pos=(%0d,%0d) rdy=%b want (0,0) rdy=0", cur_col, cur_row, wr_ready);
    end
    tick();
    rst = 1'b0;
    wait_ready(n);
    total++;
    if (n != 1200) begin
      bad++;
      $display("FAIL midrst_clear_len got %0d cycles want 1200", n);
    end
    rd_px(0, 16, d);
    total++;
    if (d !== 7'h00) begin
      bad++;
      $display("FAIL midrst_cell got %h want 00", d);
    end
  endtask

  task automatic test_cursor();
    logic prev;
    int last;
    int changes;
    int bad_gap;
    i_x = 12'd5;
    i_y = 12'd5;
    tick();
    prev    = o_cursor;
    last    = -1;
    changes = 0;
    bad_gap = 0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (o_cursor !== prev) begin
        if (last >= 0 && (k - last) != 8) bad_gap++;
        last = k;
        changes++;
        prev = o_cursor;
      end
    end
`ifdef TEXT_CONSOLE_CURSOR_EN
    total++;
    if (changes < 4 || bad_gap != 0) begin
      bad++;
      $display("FAIL cursor_blink got changes=%0d bad_gaps=%0d want >=4 changes every 8 cycles", changes, bad_gap);
    end
`else
    total++;
    if (changes != 0 || o_cursor !== 1'b0) begin
      bad++;
      $display("FAIL cursor_off got changes=%0d cur=%b want 0 changes cur=0", changes, o_cursor);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_form_feed();
    test_line_wrap();
    test_lf_wrap();
    test_backspace();
    test_cr_oob();
    test_reset_mid_clear();
    test_cursor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/text_console.md
Name: text_console

Overview:
- Character frame store and writer feeding the glyph renderer (`gfx`).
- Accepts an ASCII character stream from the calculator core over a valid/ready handshake and places characters at a cursor.
- Handles control codes, line wrap and screen clear.
- Serves the 7-bit character code for any pixel coordinate on a read port that `gfx` consumes directly.

Parameters:
- COLS, 40, character columns (16-px cells; 40 = 640 px).
- ROWS, 30, character rows (30 = 480 px).
- BLINK_LOG2, 24, blink counter width; cursor toggles every 2^(BLINK_LOG2-1) clocks (optional feature only).

Ports:
- pix_clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  wr_char is valid.
- wr_char  in  7  ASCII code to write.
- wr_ready  out  1  block can accept a character this cycle.
- i_x  in  12  pixel x being rendered.
- i_y  in  12  pixel y being rendered.
- character  out  7  code of the cell containing (i_x,i_y); to gfx.
- o_cursor  out  1  rendered cell is the cursor cell and blink phase is on.
- cur_col  out  $clog2(COLS)  cursor column.
- cur_row  out  $clog2(ROWS)  cursor row.

Behaviour:
- Reset
  - Clock is pix_clk; reset is asynchronous, active-high (rst).
  - On rst: state=CLEAR_ALL, clear pointer=0, cur_col=0, cur_row=0, wr_ready=0, character=7'h00, o_cursor=0.
- Storage
  - COLS*ROWS x 7-bit simple dual-port RAM.
  - Address = row*COLS + col.
  - Blank value = 7'h00 (renders black in gfx).
- State machine: IDLE, CLEAR_ROW, CLEAR_ALL.
  - CLEAR_ALL: writes 7'h00 to one cell per clock, addresses 0..COLS*ROWS-1; wr_ready=0. After the last address goes to IDLE; cursor stays (0,0). Takes exactly COLS*ROWS cycles.
  - CLEAR_ROW: writes 7'h00 to cells (cur_row,0..COLS-1), one per clock; wr_ready=0. Takes COLS cycles, then goes to IDLE.
  - IDLE: wr_ready=1. A transfer occurs on a rising edge where wr_valid&&wr_ready.
- Transfer actions, all applied at the acceptance edge
  - 7'h20..7'h7E:
    - Write the code at the cursor, then advance: col+1.
    - If col==COLS-1: col=0, row+1.
    - If row was ROWS-1: row wraps to 0.
    - Whenever the row changes by advance, enter CLEAR_ROW for the new row.
  - 7'h0A or 7'h0D: col=0, row+1 with the same wrap rule, then CLEAR_ROW.
  - 7'h08 (backspace):
    - If col>0: col-1.
    - Else if row>0: col=COLS-1, row-1.
    - Else no move.
    - Then write 7'h00 at the new cursor position. No clear.
  - 7'h0C: cursor=(0,0), enter CLEAR_ALL.
  - Any other code: consumed, no effect.
- wr_valid may stay high; one character is consumed per accepted edge. wr_ready drops in the cycle after any row change or form feed.
- Read port
  - col = i_x>>4, row = i_y>>4.
  - character is registered with 1-cycle latency from i_x/i_y.
  - If col>=COLS or row>=ROWS, character=7'h00.
  - Read is independent of writes. A cell written at edge N is returned for reads sampled at edge N+1 or later. A same-edge collision may return the old data.
  - During a clear, reads return current contents (partially cleared).
- Reset mid-operation: rst aborts any clear or transfer immediately and restarts CLEAR_ALL on deassertion.

Optional Feature:
- Macro: TEXT_CONSOLE_CURSOR_EN.
- Defined:
  - Free-running BLINK_LOG2-bit counter, reset to 0.
  - o_cursor is registered with the same 1-cycle latency as character.
  - o_cursor = (read col,row == cur_col,cur_row) && counter MSB.
  - o_cursor=0 while state!=IDLE.
- Undefined: no counter; o_cursor tied to 0.

Decomposition:
- Package gfx_pkg holds:
  - CELL_PX=16, CELL_SHIFT=4.
  - CHR_BS=7'h08, CHR_LF=7'h0A, CHR_FF=7'h0C, CHR_CR=7'h0D, CHR_BLANK=7'h00.
  - Printable bounds 7'h20/7'h7E.
  - typedef enum logic[1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} console_state_t.
- One sub-module: char_ram.
  - Simple dual-port: one write port, one synchronous read port.
  - Parameterised depth/width.
  - No reset on the array.

Test Plan (COLS=40, ROWS=30):
- rst pulse then release: wr_ready=0 for exactly 1200 cycles, then 1. Reads of every cell = 7'h00; cur=(0,0).
- Write "1","+","2" (7'h31,7'h2B,7'h32) with wr_valid held: 3 transfers on consecutive cycles. Read at i_x=16,i_y=0 returns 7'h2B one cycle later; cur_col=3.
- Write 40 printable chars from (0,0): the 40th gives cur=(0,1) and wr_ready=0 for 40 cycles. Row 1 reads 7'h00; row 0 col 39 holds the 40th char.
- From cur=(0,29), write 7'h0A: cur=(0,0), row 0 cleared in 40 cycles, rows 1..29 unchanged.
- Backspace at (0,1) after row 0 filled: cur=(39,0); cell (39,0) reads 7'h00. Backspace at (0,0): no move, cell (0,0) becomes 7'h00.
- Read at i_x=640,i_y=0 and i_x=0,i_y=480 -> 7'h00. Assert rst during CLEAR_ROW -> cursor (0,0), full 1200-cycle clear repeats. With TEXT_CONSOLE_CURSOR_EN, BLINK_LOG2=4: o_cursor toggles every 8 cycles when reading the cursor cell.
